bin_plus_checker: RTL and testbench

- Self-checking stimulus/response engine for the packed mixed-width binary-plus cosim block.
- Drives the 128-bit packed operand vector `in_vec` from an LFSR and waits a fixed latency.
- Samples the DUT's packed 128-bit result `out_vec` and recomputes all ten sums internally under Verilog width/sign rules.
- Counts mismatches per field. Sits beside the DUT in the cosim harness and is the consumer end of its in/out vector interface.

---
 rtl/bin_plus_checker.sv | 186 ++++++++++++++++++
 tb/tb_bin_plus_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_plus_checker.sv
// Stimulus/response checker for the packed mixed-width binary-plus block.
// Drives LFSR operands on in_vec, samples out_vec after LATENCY cycles and tallies per-field mismatches.
module bin_plus_checker #(
    parameter logic [31:0] SEED        = 32'h0000_0001,
    parameter int          NUM_VECTORS = 16,
    parameter int          LATENCY     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [127:0] in_vec,
    input  logic [127:0] out_vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic [15:0]  first_fail_idx,
    output logic [10:0]  fail_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  WAIT_LOAD = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [15:0] NO_FAIL   = 16'hFFFF;

    state_t        state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [127:0]  in_vec_q, in_vec_d;
    logic [15:0]   idx_q, idx_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [15:0]   err_count_q, err_count_d;
    logic [15:0]   first_fail_q, first_fail_d;
    logic [10:0]   fail_mask_q, fail_mask_d;

    logic [31:0]   lfsr_next;
    logic [8:0]    a9, b9;
    logic [3:0]    a4;
    logic          a1;
    logic [5:0]    b6;
    logic [1:0]    b2;
    logic [8:0]    usum9;
    logic signed [8:0] ssum9;
    logic [3:0]    sum_o2, sum_o7;
    logic [15:0]   sum_o4, sum_o9;
    logic [6:0]    sum_o10;
    logic          sum_o3, sum_o8;
    logic [73:0]   exp_vec;
    logic [10:0]   field_err;
    logic          any_err;

    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);

    assign a9 = in_vec_q[30:22];
    assign a4 = in_vec_q[21:18];
    assign a1 = in_vec_q[17];
    assign b9 = in_vec_q[16:8];
    assign b6 = in_vec_q[7:2];
    assign b2 = in_vec_q[1:0];

    // Truncated fields only need the low operand bits, so sign extension reduces to the slice.
    assign usum9   = a9 + b9;
    assign ssum9   = $signed(a9) + $signed(b9);
    assign sum_o2  = a4 + b6[3:0];
    assign sum_o3  = a1 ^ b2[0];
    assign sum_o4  = {7'd0, a9} + {10'd0, b6};
    assign sum_o7  = a4 + b6[3:0];
    assign sum_o8  = a1 ^ b2[0];
    assign sum_o9  = {{7{a9[8]}}, a9} + {{10{b6[5]}}, b6};
    assign sum_o10 = a9[6:0] + {{5{b2[1]}}, b2};

    assign exp_vec = {sum_o10, sum_o9, sum_o8, sum_o7, ssum9, usum9[6:0],
                      sum_o4, sum_o3, sum_o2, usum9};

    // Case inequality so X/Z from the DUT always registers as a mismatch.
    always_comb begin
        field_err     = '0;
        field_err[0]  = (out_vec[8:0]    !== exp_vec[8:0]);
        field_err[1]  = (out_vec[12:9]   !== exp_vec[12:9]);
        field_err[2]  = (out_vec[13]     !== exp_vec[13]);
        field_err[3]  = (out_vec[29:14]  !== exp_vec[29:14]);
        field_err[4]  = (out_vec[36:30]  !== exp_vec[36:30]);
        field_err[5]  = (out_vec[45:37]  !== exp_vec[45:37]);
        field_err[6]  = (out_vec[49:46]  !== exp_vec[49:46]);
        field_err[7]  = (out_vec[50]     !== exp_vec[50]);
        field_err[8]  = (out_vec[66:51]  !== exp_vec[66:51]);
        field_err[9]  = (out_vec[73:67]  !== exp_vec[73:67]);
        field_err[10] = (out_vec[127:74] !== 54'd0);
    end

    assign any_err = |field_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED_EFF;
            in_vec_q     <= '0;
            idx_q        <= '0;
            wait_cnt_q   <= '0;
            err_count_q  <= '0;
            first_fail_q <= NO_FAIL;
            fail_mask_q  <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            in_vec_q     <= in_vec_d;
            idx_q        <= idx_d;
            wait_cnt_q   <= wait_cnt_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_mask_q  <= fail_mask_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        in_vec_d     = in_vec_q;
        idx_d        = idx_q;
        wait_cnt_d   = wait_cnt_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_mask_d  = fail_mask_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_DRIVE;
                    lfsr_d       = SEED_EFF;
                    idx_d        = '0;
                    err_count_d  = '0;
                    first_fail_d = NO_FAIL;
                    fail_mask_d  = '0;
                end
            end
            S_DRIVE: begin
                in_vec_d   = {97'd0, lfsr_q[30:0]};
                wait_cnt_d = WAIT_LOAD;
                state_d    = (LATENCY > 0) ? S_WAIT : S_CHECK;
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (any_err) begin
                    if (err_count_q != 16'hFFFF) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    if (first_fail_q == NO_FAIL) begin
                        first_fail_d = idx_q;
                    end
                end
                fail_mask_d = fail_mask_q | field_err;
                lfsr_d      = lfsr_next;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_vec         = in_vec_q;
    assign busy           = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_count_q == 16'd0);
    assign err_count      = err_count_q;
    assign first_fail_idx = first_fail_q;
    assign fail_mask      = fail_mask_q;

endmodule

// File: tb/tb_bin_plus_checker.sv
// Bench for bin_plus_checker: four checker instances fed by behavioural binary-plus stand-ins,
// a table of whole-run outcomes plus hand sequences for restart, ignored start and mid-run reset.
module tb_bin_plus_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0]         start_s = '0;
    logic [3:0][127:0]  in_v;
    logic [3:0][127:0]  out_v;
    logic [3:0]         busy_s, done_s, pass_s;
    logic [3:0][15:0]   err_s, ffi_s;
    logic [3:0][10:0]   mask_s;
    logic               force_hi = 1'b0;
    logic [127:0]       b_p1 = '0, b_p2 = '0, b_p3 = '0;
    logic [127:0]       c_p1 = '0, c_p2 = '0, c_p3 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural binary-plus block written with ordinary Verilog width/sign semantics.
    function automatic logic [127:0] ref_sum(input logic [127:0] iv);
        logic [8:0] a9, b9;
        logic [3:0] a4;
        logic       a1;
        logic [5:0] b6;
        logic [1:0] b2;
        logic signed [8:0] c9, d9;
        logic signed [3:0] c4;
        logic signed       c1;
        logic signed [5:0] d6;
        logic signed [1:0] d2;
        logic [9:0]  s1;
        logic [5:0]  s2;
        logic [1:0]  s3;
        logic [15:0] s4;
        logic signed [9:0]  s6;
        logic signed [5:0]  s7;
        logic signed [1:0]  s8;
        logic signed [15:0] s9;
        logic signed [8:0]  s10;
        a9 = iv[30:22]; a4 = iv[21:18]; a1 = iv[17];
        b9 = iv[16:8];  b6 = iv[7:2];   b2 = iv[1:0];
        c9 = a9; c4 = a4; c1 = a1; d9 = b9; d6 = b6; d2 = b2;
        s1  = 10'(a9) + 10'(b9);
        s2  = 6'(a4) + b6;
        s3  = 2'(a1) + b2;
        s4  = 16'(a9) + 16'(b6);
        s6  = 10'(c9) + 10'(d9);
        s7  = 6'(c4) + d6;
        s8  = 2'(c1) + d2;
        s9  = 16'(c9) + 16'(d6);
        s10 = c9 + 9'(d2);
        return {54'd0, s10[6:0], s9, s8[0], s7[3:0], s6[8:0], s1[6:0], s4, s3[0], s2[3:0], s1[8:0]};
    endfunction

    always @(posedge clk) begin
        b_p1 <= ref_sum(in_v[1]); b_p2 <= b_p1; b_p3 <= b_p2;
        c_p1 <= ref_sum(in_v[2]); c_p2 <= c_p1; c_p3 <= c_p2;
    end

    always_comb begin
        out_v    = '0;
        out_v[0] = ref_sum(in_v[0]) | (force_hi ? (128'd1 << 100) : 128'd0);
        out_v[1] = b_p3;
        out_v[2] = c_p3;
        out_v[3] = '0;
    end

    bin_plus_checker #(.SEED(32'h1), .NUM_VECTORS(4), .LATENCY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_vec(in_v[0]), .out_vec(out_v[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
        .first_fail_idx(ffi_s[0]), .fail_mask(mask_s[0]));

    bin_plus_checker #(.SEED(32'h1), .NUM_VECTORS(16), .LATENCY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_vec(in_v[1]), .out_vec(out_v[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
        .first_fail_idx(ffi_s[1]), .fail_mask(mask_s[1]));

    bin_plus_checker #(.SEED(32'h1), .NUM_VECTORS(16), .LATENCY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_vec(in_v[2]), .out_vec(out_v[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err_s[2]),
        .first_fail_idx(ffi_s[2]), .fail_mask(mask_s[2]));

    bin_plus_checker #(.SEED(32'h0), .NUM_VECTORS(1), .LATENCY(0)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_s[3]), .in_vec(in_v[3]), .out_vec(out_v[3]),
        .busy(busy_s[3]), .done(done_s[3]), .pass(pass_s[3]), .err_count(err_s[3]),
        .first_fail_idx(ffi_s[3]), .fail_mask(mask_s[3]));

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start on one instance and count cycles from the start edge until done.
    task automatic applyStimulus(input int sel, output int cycles, output logic [127:0] first_in);
        @(posedge clk); #1 start_s[sel] = 1'b1;
        @(posedge clk); #1 start_s[sel] = 1'b0;
        cycles   = 0;
        first_in = '0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (c == 1) first_in = in_v[sel];
            if (done_s[sel]) begin
                cycles = c;
                break;
            end
        end
    endtask

    typedef struct {
        int          sel;
        logic        force_hi;
        int          exp_cycles;
        logic        err_exact;
        logic [15:0] exp_err;
        logic [15:0] exp_ffi;
        logic        check_mask;
        logic [10:0] exp_mask;
        logic        exp_pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc;
        logic [127:0] first;

        tbl[0] = '{0, 1'b0,  8, 1'b1, 16'd0, 16'hFFFF, 1'b1, 11'h000, 1'b1};
        tbl[1] = '{3, 1'b0,  2, 1'b1, 16'd1, 16'd0,    1'b1, 11'h284, 1'b0};
        tbl[2] = '{1, 1'b0, 80, 1'b1, 16'd0, 16'hFFFF, 1'b1, 11'h000, 1'b1};
        tbl[3] = '{2, 1'b0, 64, 1'b0, 16'd0, 16'd0,    1'b0, 11'h000, 1'b0};
        tbl[4] = '{0, 1'b1,  8, 1'b1, 16'd4, 16'd0,    1'b1, 11'h400, 1'b0};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rst%0d in_vec", k), in_v[k], 128'd0);
            checkOutput($sformatf("rst%0d busy", k), 128'(busy_s[k]), 128'd0);
            checkOutput($sformatf("rst%0d done", k), 128'(done_s[k]), 128'd0);
            checkOutput($sformatf("rst%0d pass", k), 128'(pass_s[k]), 128'd0);
            checkOutput($sformatf("rst%0d err", k), 128'(err_s[k]), 128'd0);
            checkOutput($sformatf("rst%0d ffi", k), 128'(ffi_s[k]), 128'hFFFF);
            checkOutput($sformatf("rst%0d mask", k), 128'(mask_s[k]), 128'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            force_hi = tbl[i].force_hi;
            applyStimulus(tbl[i].sel, cyc, first);
            checkOutput($sformatf("row%0d cycles", i), 128'(cyc), 128'(tbl[i].exp_cycles));
            checkOutput($sformatf("row%0d first in_vec", i), first, 128'h1);
            if (tbl[i].err_exact)
                checkOutput($sformatf("row%0d err", i), 128'(err_s[tbl[i].sel]), 128'(tbl[i].exp_err));
            else
                checkOutput($sformatf("row%0d err nonzero", i), 128'(err_s[tbl[i].sel] != 16'd0), 128'd1);
            checkOutput($sformatf("row%0d ffi", i), 128'(ffi_s[tbl[i].sel]), 128'(tbl[i].exp_ffi));
            if (tbl[i].check_mask)
                checkOutput($sformatf("row%0d mask", i), 128'(mask_s[tbl[i].sel]), 128'(tbl[i].exp_mask));
            checkOutput($sformatf("row%0d pass", i), 128'(pass_s[tbl[i].sel]), 128'(tbl[i].exp_pass));
            checkOutput($sformatf("row%0d busy", i), 128'(busy_s[tbl[i].sel]), 128'd0);
        end

        // Restart from DONE clears results at once; a start while busy is ignored.
        force_hi = 1'b0;
        @(posedge clk); #1 start_s[0] = 1'b1;
        @(posedge clk); #1 start_s[0] = 1'b0;
        checkOutput("restart err cleared", 128'(err_s[0]), 128'd0);
        checkOutput("restart mask cleared", 128'(mask_s[0]), 128'd0);
        checkOutput("restart ffi cleared", 128'(ffi_s[0]), 128'hFFFF);
        checkOutput("restart busy", 128'(busy_s[0]), 128'd1);
        checkOutput("restart in_vec held", in_v[0], 128'h6018_0001);
        @(posedge clk); #1;
        checkOutput("restart in_vec v0", in_v[0], 128'h1);
        start_s[0] = 1'b1;
        @(posedge clk); #1 start_s[0] = 1'b0;
        @(posedge clk); #1;
        checkOutput("busy start in_vec v1", in_v[0], 128'h0020_0003);
        repeat (2) @(posedge clk); #1;
        checkOutput("busy start in_vec v2", in_v[0], 128'h4030_0002);
        repeat (2) @(posedge clk); #1;
        checkOutput("busy start in_vec v3", in_v[0], 128'h6018_0001);
        checkOutput("busy start not done", 128'(done_s[0]), 128'd0);
        @(posedge clk); #1;
        checkOutput("busy start done", 128'(done_s[0]), 128'd1);
        checkOutput("busy start pass", 128'(pass_s[0]), 128'd1);

        // Reset pulse in the WAIT phase of vector 5, then a clean rerun from SEED.
        @(posedge clk); #1 start_s[1] = 1'b1;
        @(posedge clk); #1 start_s[1] = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        checkOutput("wait v5 busy", 128'(busy_s[1]), 128'd1);
        checkOutput("wait v5 in_vec", in_v[1], 128'h5836_0002);
        rst_n = 1'b0;
        #1;
        checkOutput("abort in_vec", in_v[1], 128'd0);
        checkOutput("abort busy", 128'(busy_s[1]), 128'd0);
        checkOutput("abort done", 128'(done_s[1]), 128'd0);
        checkOutput("abort err", 128'(err_s[1]), 128'd0);
        checkOutput("abort ffi", 128'(ffi_s[1]), 128'hFFFF);
        checkOutput("abort mask", 128'(mask_s[1]), 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        applyStimulus(1, cyc, first);
        checkOutput("rerun first in_vec", first, 128'h1);
        checkOutput("rerun cycles", 128'(cyc), 128'd80);
        checkOutput("rerun pass", 128'(pass_s[1]), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
